ws2812_stream_tx: RTL and testbench
===================================

Name: ws2812_stream_tx

Overview:
Parametrised successor to the single-word WS2812B driver. It accepts pixel words of configurable width (24-bit GRB or 32-bit GRBW) through a valid/ready interface into an internal FIFO. It serialises them MSB-first onto one LED data line with no inter-word gap, and issues the latch/reset low interval only when a word is tagged with latch. It sits between the byte-peripheral register interface and the chip pin, and adds optional output inversion for external inverting level shifters.

Parameters:
CLOCK_MHZ, 64, clk frequency in MHz; all cycle counts are derived from it.
BPP, 24, bits per pixel word; legal values 24 or 32.
DEPTH, 4, FIFO depth in words; power of 2, at least 2.
T0H_NS, 400, high time of a '0' bit.
T1H_NS, 800, high time of a '1' bit.
PERIOD_NS, 1250, total bit period.
RES_NS, 325000, latch/reset low interval.
INVERT, 0, 1 inverts the led output level.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_in  in  BPP  pixel word, sent MSB first
latch_in  in  1  when 1, the reset interval follows this word
in_valid  in  1  word offered
in_ready  out  1  FIFO can accept; equals (fifo_level < DEPTH)
fifo_level  out  $clog2(DEPTH)+1  words stored
busy  out  1  serializer not in IDLE, or FIFO non-empty
frame_done  out  1  one-cycle pulse when a latch reset interval completes
led  out  1  serial data line (raw level XOR INVERT)

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - rst_n low at a clk edge: FIFO emptied, fifo_level 0, frame_done 0, led = INVERT (idle low), serializer enters RESET with the power-on flag set.
  - in_ready is 1 from the first cycle after reset.
- Cycle counts: C = round(CLOCK_MHZ*ns/1000), computed as 64-bit and truncated to 16 bits. Derived counts are CP (PERIOD), C0 (T0H), C1 (T1H) and CR (RES). Defaults: CP=80, C0=26, C1=51, CR=20800. CR must be < 65536.
- FIFO:
  - Push when in_valid && in_ready. Each entry stores {latch_in, data_in}.
  - Pop occurs only in IDLE/next-word transitions. Push and pop in the same cycle leave the level unchanged.
  - There is no push when full; in_ready is combinational from the level.
- Serializer states: IDLE, SEND, RESET.
  - IDLE:
    - raw led 0.
    - If the FIFO is non-empty: pop into the shift register, raw led 1, counter 0, bit index BPP-1, go to SEND.
    - A word accepted at edge N therefore drives led high after edge N+1.
  - SEND:
    - The counter runs 0..CP-1 per bit.
    - Raw led is 1 for counter < TH and 0 otherwise, where TH = C1 if the current bit is 1, else C0. Exactly TH cycles high, CP-TH cycles low.
    - At counter CP-1 with bit index > 0: next bit, counter 0, raw led 1.
    - At counter CP-1 with the last bit and latch tag set: go to RESET, raw led 0, counter 0.
    - At counter CP-1 with the last bit, no latch tag and the FIFO non-empty: pop the next word and start its MSB on the next cycle. There is no gap; the period stays exactly CP.
    - At counter CP-1 with the last bit, no latch tag and the FIFO empty (underrun): go to IDLE with raw led 0. A later word starts as from IDLE.
  - RESET:
    - Raw led 0 for CR cycles; counter counts 0..CR-1, then go to IDLE.
    - On exit, frame_done pulses for 1 cycle unless the power-on flag is set; the flag is cleared on exit.
    - The FIFO continues to accept pushes during RESET.
- busy falls in the same cycle IDLE is entered with the FIFO empty.
- rst_n asserted mid-bit or mid-reset: aborts immediately per reset rules; the partial word is discarded.

Test Plan:
1. Default params, release rst_n, no input -> led stays 0 for 20800 cycles; in_ready=1 throughout; frame_done never pulses; busy falls after the power-on reset interval.
2. After idle, push 0xA00000 with latch_in=1 -> led rises 2 edges after acceptance; high widths 51,26,51,26, then 26×20; each bit period 80 cycles; then led low 20800 cycles; frame_done pulses exactly once; busy falls.
3. Push 3 words back-to-back (0xFF0000, 0x00FF00, 0x0000FF), latch only on the third -> 72 contiguous 80-cycle bit periods with no gap; a single reset interval; one frame_done.
4. DEPTH=4: while word 0 is sending, push continuously -> exactly 4 further words accepted; fifo_level=4 and in_ready=0 until the next pop; output order matches push order.
5. BPP=32, INVERT=1: push 0xFFFFFFFF with latch_in=1 -> idle level 1; 32 low pulses of 51 cycles within 80-cycle periods; then 20800 cycles high.
6. Assert rst_n low at counter=10 of bit 5 with 2 words queued -> led=INVERT after that edge; fifo_level=0; after release, a 20800-cycle reset interval elapses with no frame_done.

Source files
------------

// File: rtl/ws2812_stream_tx.sv
// WS2812-family LED line driver: buffers pixel words in a small FIFO and serialises them
// MSB-first back to back, inserting the latch low interval only after words tagged latch.
module ws2812_stream_tx #(
    parameter int CLOCK_MHZ = 64,
    parameter int BPP       = 24,
    parameter int DEPTH     = 4,
    parameter int T0H_NS    = 400,
    parameter int T1H_NS    = 800,
    parameter int PERIOD_NS = 1250,
    parameter int RES_NS    = 325000,
    parameter int INVERT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BPP-1:0]           data_in,
    input  logic                     latch_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     led
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(BPP);

    // Rounded cycle counts, computed wide and then narrowed to the counter width.
    localparam logic [63:0] CP_W = (64'(CLOCK_MHZ) * 64'(PERIOD_NS) + 64'd500) / 64'd1000;
    localparam logic [63:0] C0_W = (64'(CLOCK_MHZ) * 64'(T0H_NS)    + 64'd500) / 64'd1000;
    localparam logic [63:0] C1_W = (64'(CLOCK_MHZ) * 64'(T1H_NS)    + 64'd500) / 64'd1000;
    localparam logic [63:0] CR_W = (64'(CLOCK_MHZ) * 64'(RES_NS)    + 64'd500) / 64'd1000;
    localparam logic [15:0] CP = CP_W[15:0];
    localparam logic [15:0] C0 = C0_W[15:0];
    localparam logic [15:0] C1 = C1_W[15:0];
    localparam logic [15:0] CR = CR_W[15:0];

    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] MSB_IDX  = IW'(BPP - 1);
    localparam logic          INV_L    = (INVERT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_RESET = 2'd2
    } state_t;

    // ---------------- FIFO ----------------
    logic [BPP:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [BPP:0]  head;
    logic          push;
    logic          pop;
    logic          fifo_nempty;

    assign in_ready    = (level_q < DEPTH_L);
    assign push        = in_valid && in_ready;
    assign fifo_nempty = (level_q != '0);
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {latch_in, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- Serializer ----------------
    state_t         state_q;
    logic [15:0]    cnt_q;
    logic [IW-1:0]  bit_idx_q;
    logic [BPP-1:0] shift_q;
    logic           latch_q;
    logic           por_q;
    logic           raw_q;
    logic           done_q;

    logic           bit_end;
    logic           last_bit;
    logic [15:0]    cur_th;
    logic [15:0]    next_cnt;

    assign bit_end  = (cnt_q == CP - 16'd1);
    assign last_bit = (bit_idx_q == '0);
    assign cur_th   = shift_q[BPP-1] ? C1 : C0;
    assign next_cnt = cnt_q + 16'd1;

    // A pop happens from IDLE, or back-to-back when an untagged word finishes its last bit.
    assign pop = fifo_nempty &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_SEND) && bit_end && last_bit && !latch_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            por_q     <= 1'b1;
            raw_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    raw_q <= 1'b0;
                    if (fifo_nempty) begin
                        shift_q   <= head[BPP-1:0];
                        latch_q   <= head[BPP];
                        bit_idx_q <= MSB_IDX;
                        cnt_q     <= '0;
                        raw_q     <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (!bit_end) begin
                        cnt_q <= next_cnt;
                        raw_q <= (next_cnt < cur_th);
                    end else if (!last_bit) begin
                        shift_q   <= shift_q << 1;
                        bit_idx_q <= bit_idx_q - IW'(1);
                        cnt_q     <= '0;
                        raw_q     <= 1'b1;
                    end else if (latch_q) begin
                        state_q <= ST_RESET;
                        cnt_q   <= '0;
                        raw_q   <= 1'b0;
                    end else if (fifo_nempty) begin
                        // Next word's MSB starts right away so the bit period never stretches.
                        shift_q   <= head[BPP-1:0];
                        latch_q   <= head[BPP];
                        bit_idx_q <= MSB_IDX;
                        cnt_q     <= '0;
                        raw_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        raw_q   <= 1'b0;
                    end
                end

                ST_RESET: begin
                    raw_q <= 1'b0;
                    if (cnt_q == CR - 16'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        done_q  <= !por_q;
                        por_q   <= 1'b0;
                    end else begin
                        cnt_q <= next_cnt;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    raw_q   <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_level = level_q;
    assign busy       = (state_q != ST_IDLE) || fifo_nempty;
    assign frame_done = done_q;
    assign led        = raw_q ^ INV_L;

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Bench for ws2812_stream_tx: two instances (24-bit plain, 32-bit inverted) checked against
// an arithmetic timeline model of the expected LED waveform.
module tb_ws2812_stream_tx;

    localparam int A_RES = 10000;
    localparam int B_MHZ = 50;
    localparam int B_RES = 8000;

    logic        clk;
    logic        a_rst_n, a_latch, a_valid, a_ready, a_busy, a_fd, a_led;
    logic [23:0] a_data;
    logic [2:0]  a_level;
    logic        b_rst_n, b_latch, b_valid, b_ready, b_busy, b_fd, b_led;
    logic [31:0] b_data;
    logic [2:0]  b_level;

    int   passed = 0;
    int   total  = 0;
    int   cp_s[2], c0_s[2], c1_s[2], cr_s[2];
    logic inv_s[2];
    bit   exp_bits[$];

    ws2812_stream_tx #(
        .CLOCK_MHZ(64), .BPP(24), .DEPTH(4), .T0H_NS(400), .T1H_NS(800),
        .PERIOD_NS(1250), .RES_NS(A_RES), .INVERT(0)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .data_in(a_data), .latch_in(a_latch),
        .in_valid(a_valid), .in_ready(a_ready), .fifo_level(a_level),
        .busy(a_busy), .frame_done(a_fd), .led(a_led)
    );

    ws2812_stream_tx #(
        .CLOCK_MHZ(B_MHZ), .BPP(32), .DEPTH(4), .T0H_NS(400), .T1H_NS(800),
        .PERIOD_NS(1250), .RES_NS(B_RES), .INVERT(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .data_in(b_data), .latch_in(b_latch),
        .in_valid(b_valid), .in_ready(b_ready), .fifo_level(b_level),
        .busy(b_busy), .frame_done(b_fd), .led(b_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ncyc(input int mhz, input int ns);
        return $rtoi(real'(mhz) * real'(ns) / 1000.0 + 0.5);
    endfunction

    function automatic logic get_led(input int s);   return (s == 0) ? a_led   : b_led;   endfunction
    function automatic logic get_busy(input int s);  return (s == 0) ? a_busy  : b_busy;  endfunction
    function automatic logic get_fd(input int s);    return (s == 0) ? a_fd    : b_fd;    endfunction
    function automatic logic get_ready(input int s); return (s == 0) ? a_ready : b_ready; endfunction
    function automatic logic [2:0] get_level(input int s); return (s == 0) ? a_level : b_level; endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic add_word(input int bpp, input logic [31:0] w);
        for (int b = bpp - 1; b >= 0; b--) exp_bits.push_back(w[b]);
    endtask

    task automatic push(input int s, input logic [31:0] w, input logic l);
        if (s == 0) begin
            a_data = w[23:0]; a_latch = l; a_valid = 1'b1;
            step();
            a_valid = 1'b0; a_latch = 1'b0;
        end else begin
            b_data = w; b_latch = l; b_valid = 1'b1;
            step();
            b_valid = 1'b0; b_latch = 1'b0;
        end
    endtask

    // Current cycle is t_start relative to the cycle the first bit goes high.
    task automatic check_wave(input int s, input bit latched, input int t_start, input string tag);
        int   nb, cp, endt, th;
        int   bad_led, bad_fd, bad_busy;
        logic exp_raw;
        nb   = exp_bits.size();
        cp   = cp_s[s];
        endt = nb * cp + (latched ? cr_s[s] : 0);
        bad_led = -1; bad_fd = -1; bad_busy = -1;
        for (int t = t_start; t <= endt; t++) begin
            if (t != t_start) step();
            exp_raw = 1'b0;
            if (t >= 0 && t < nb * cp) begin
                th = exp_bits[t / cp] ? c1_s[s] : c0_s[s];
                exp_raw = ((t % cp) < th);
            end
            if (bad_led  < 0 && get_led(s)  !== (exp_raw ^ inv_s[s]))     bad_led  = t;
            if (bad_fd   < 0 && get_fd(s)   !== (latched && (t == endt))) bad_fd   = t;
            if (bad_busy < 0 && get_busy(s) !== (t < endt))               bad_busy = t;
        end
        chk({tag, "_led_first_bad_cycle"},  bad_led,  -1);
        chk({tag, "_done_first_bad_cycle"}, bad_fd,   -1);
        chk({tag, "_busy_first_bad_cycle"}, bad_busy, -1);
        chk({tag, "_level_after"}, get_level(s), 0);
        exp_bits.delete();
    endtask

    // Current cycle is the one right after the last edge with rst_n low.
    task automatic check_reset_interval(input int s, input string tag);
        int bad_led, bad_fd, bad_busy, bad_ready;
        chk({tag, "_ready0"}, get_ready(s), 1);
        chk({tag, "_level0"}, get_level(s), 0);
        chk({tag, "_led0"},   get_led(s),   inv_s[s]);
        chk({tag, "_busy0"},  get_busy(s),  1);
        bad_led = -1; bad_fd = -1; bad_busy = -1; bad_ready = -1;
        for (int k = 1; k <= cr_s[s]; k++) begin
            step();
            if (bad_led   < 0 && get_led(s)   !== inv_s[s])       bad_led   = k;
            if (bad_fd    < 0 && get_fd(s)    !== 1'b0)           bad_fd    = k;
            if (bad_busy  < 0 && get_busy(s)  !== (k < cr_s[s]))  bad_busy  = k;
            if (bad_ready < 0 && get_ready(s) !== 1'b1)           bad_ready = k;
        end
        chk({tag, "_led_first_bad_cycle"},   bad_led,   -1);
        chk({tag, "_done_first_bad_cycle"},  bad_fd,    -1);
        chk({tag, "_busy_first_bad_cycle"},  bad_busy,  -1);
        chk({tag, "_ready_first_bad_cycle"}, bad_ready, -1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] offer[6];
        int          k, idx;
        logic        acc;

        cp_s[0] = ncyc(64, 1250);  c0_s[0] = ncyc(64, 400);  c1_s[0] = ncyc(64, 800);  cr_s[0] = ncyc(64, A_RES);
        cp_s[1] = ncyc(B_MHZ, 1250); c0_s[1] = ncyc(B_MHZ, 400); c1_s[1] = ncyc(B_MHZ, 800); cr_s[1] = ncyc(B_MHZ, B_RES);
        inv_s[0] = 1'b0; inv_s[1] = 1'b1;

        a_rst_n = 1'b0; a_data = '0; a_latch = 1'b0; a_valid = 1'b0;
        b_rst_n = 1'b0; b_data = '0; b_latch = 1'b0; b_valid = 1'b0;
        repeat (3) step();
        a_rst_n = 1'b1;

        // Power-on reset interval: quiet line, no frame_done.
        check_reset_interval(0, "a_por");

        // Single latched word: two-edge latency, then 51/26 pulse pattern and latch.
        add_word(24, 32'h00A00000);
        a_data = 24'hA00000; a_latch = 1'b1; a_valid = 1'b1;
        step();
        chk("t2_led_at_accept", a_led, 0);
        a_valid = 1'b0; a_latch = 1'b0;
        step();
        chk("t2_led_after_next_edge", a_led, 1);
        check_wave(0, 1'b1, 0, "t2");

        // Three words back to back, latch only on the last.
        add_word(24, 32'hFF0000); add_word(24, 32'h00FF00); add_word(24, 32'h0000FF);
        push(0, 32'hFF0000, 1'b0);
        push(0, 32'h00FF00, 1'b0);
        push(0, 32'h0000FF, 1'b1);
        check_wave(0, 1'b1, 1, "t3");

        // Underrun: untagged word ends in IDLE, next word starts fresh.
        w = $urandom() & 32'h00FFFFFF;
        add_word(24, w);
        push(0, w, 1'b0);
        check_wave(0, 1'b0, -1, "underrun_a");
        w = $urandom() & 32'h00FFFFFF;
        add_word(24, w);
        push(0, w, 1'b1);
        check_wave(0, 1'b1, -1, "underrun_b");

        // FIFO fill while word 0 sends.
        w = $urandom() & 32'h00FFFFFF;
        add_word(24, w);
        push(0, w, 1'b0);
        for (int i = 0; i < 6; i++) offer[i] = $urandom() & 32'h00FFFFFF;
        idx = 0;
        a_valid = 1'b1; a_data = offer[0][23:0]; a_latch = 1'b0;
        for (int c = 0; c < 20; c++) begin
            acc = a_ready;
            step();
            if (acc) begin
                idx++;
                a_data  = offer[idx][23:0];
                a_latch = (idx == 3);
            end
        end
        a_valid = 1'b0; a_latch = 1'b0;
        chk("t4_accepted", idx, 4);
        chk("t4_level_full", a_level, 4);
        chk("t4_ready_full", a_ready, 0);
        for (int i = 0; i < 4; i++) add_word(24, offer[i]);
        check_wave(0, 1'b1, 19, "t4");

        // Random multi-word frames.
        for (int f = 0; f < 2; f++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                w = $urandom() & 32'h00FFFFFF;
                add_word(24, w);
                push(0, w, (i == k - 1));
            end
            check_wave(0, 1'b1, k - 2, $sformatf("rand_a%0d", f));
        end

        // Reset mid-bit with two words queued.
        push(0, 32'h123456, 1'b0);
        push(0, 32'h654321, 1'b0);
        push(0, 32'hABCDEF, 1'b1);
        repeat (409) step();
        chk("t6_level_before", a_level, 2);
        a_rst_n = 1'b0;
        step();
        chk("t6_led_in_reset", a_led, 0);
        chk("t6_level_in_reset", a_level, 0);
        chk("t6_done_in_reset", a_fd, 0);
        a_rst_n = 1'b1;
        check_reset_interval(0, "t6_after");

        // 32-bit inverted instance.
        b_rst_n = 1'b1;
        check_reset_interval(1, "b_por");
        add_word(32, 32'hFFFFFFFF);
        push(1, 32'hFFFFFFFF, 1'b1);
        check_wave(1, 1'b1, -1, "t5");
        for (int i = 0; i < 2; i++) begin
            w = $urandom();
            add_word(32, w);
            push(1, w, (i == 1));
        end
        check_wave(1, 1'b1, 0, "rand_b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
